uart_rx_ovs: RTL and testbench

UART_RX_OVS -- requirements
Module: uart_rx_ovs

---
 rtl/uart_rx_ovs.sv | 155 +++++++++++++++
 tb/tb_uart_rx_ovs.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
// Oversampled UART receiver: 2-flop synced rx, start-bit glitch reject, optional parity, framing check, line-idle timeout.
// Define UART_RX_MAJORITY_EN to vote each bit over three ticks around mid-bit instead of taking one sample.
module uart_rx_ovs #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int IDLE_BITS   = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_baud_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_idle,
    output logic                 o_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] DEC_IDX  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] LAST_IDX = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] ONE_T    = TW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] ONE_B    = BW'(1);
    localparam logic [15:0]   IDLE_LIM = 16'(IDLE_BITS);
    localparam logic          ODD_PAR  = (PARITY_MODE == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 r_state;
    logic                   r_rx_meta;
    logic                   r_rx_sync;
    logic                   r_smp_mid;
    logic [TW-1:0]          r_tick_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_bit;
    logic [TW-1:0]          r_idle_tick;
    logic [15:0]            r_idle_bits;
    logic                   r_idle_armed;
    logic [TW-1:0]          w_tick_nxt;
    logic                   w_sample;

    // Bit decisions happen one tick after mid-bit so the vote can include the tick after mid.
`ifdef UART_RX_MAJORITY_EN
    logic r_smp_pre;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_smp_pre <= 1'b1;
        end else if (i_baud_tick) begin
            r_smp_pre <= r_smp_mid;
        end
    end

    assign w_sample = (r_smp_pre & r_smp_mid) | (r_smp_pre & r_rx_sync) | (r_smp_mid & r_rx_sync);
`else
    assign w_sample = r_smp_mid;
`endif

    assign w_tick_nxt = (r_tick_cnt == LAST_IDX) ? '0 : r_tick_cnt + ONE_T;
    assign o_busy     = (r_state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_smp_mid    <= 1'b1;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_idle_tick  <= '0;
            r_idle_bits  <= '0;
            r_idle_armed <= 1'b1;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_idle       <= 1'b0;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            o_valid   <= 1'b0;
            o_idle    <= 1'b0;
            if (i_baud_tick) begin
                r_smp_mid <= r_rx_sync;
                case (r_state)
                    S_IDLE: begin
                        r_tick_cnt <= '0;
                        if (!r_rx_sync) begin
                            r_state     <= S_START;
                            r_idle_tick <= '0;
                            r_idle_bits <= '0;
                        end else if (r_idle_tick == LAST_IDX) begin
                            r_idle_tick <= '0;
                            if (r_idle_bits != 16'hFFFF) begin
                                r_idle_bits <= r_idle_bits + 16'd1;
                            end
                            if (r_idle_armed && (r_idle_bits + 16'd1 == IDLE_LIM)) begin
                                o_idle       <= 1'b1;
                                r_idle_armed <= 1'b0;
                            end
                        end else begin
                            r_idle_tick <= r_idle_tick + ONE_T;
                        end
                    end
                    S_START: begin
                        r_tick_cnt <= w_tick_nxt;
                        if (r_tick_cnt == DEC_IDX) begin
                            if (!w_sample) begin
                                r_state   <= S_DATA;
                                r_bit_cnt <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_DATA: begin
                        r_tick_cnt <= w_tick_nxt;
                        if (r_tick_cnt == DEC_IDX) begin
                            r_shift   <= {w_sample, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + ONE_B;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                            end
                        end
                    end
                    S_PARITY: begin
                        r_tick_cnt <= w_tick_nxt;
                        if (r_tick_cnt == DEC_IDX) begin
                            r_par_bit <= w_sample;
                            r_state   <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        r_tick_cnt <= w_tick_nxt;
                        if (r_tick_cnt == DEC_IDX) begin
                            r_state      <= S_IDLE;
                            o_valid      <= 1'b1;
                            o_data       <= r_shift;
                            o_frame_err  <= ~w_sample;
                            o_parity_err <= (PARITY_MODE != 0) && ((^r_shift ^ r_par_bit) != ODD_PAR);
                            r_idle_armed <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: scoreboarded frames on a default (8N1) and an even-parity instance.
`timescale 1ns/1ps
module tb_uart_rx_ovs;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic       rx_a  = 1'b1;
    logic       rx_b  = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, perr_a, ferr_a, idle_a, busy_a;
    logic       valid_b, perr_b, ferr_b, idle_b, busy_b;

    int n_cmp = 0;
    int n_err = 0;
    int tick_total = 0;
    int idle_cnt_a = 0;
    int last_valid_tick_a = 0;
    int last_idle_tick_a = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    uart_rx_ovs u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_baud_tick(tick), .i_rx(rx_a),
        .o_data(data_a), .o_valid(valid_a), .o_parity_err(perr_a),
        .o_frame_err(ferr_a), .o_idle(idle_a), .o_busy(busy_a)
    );

    uart_rx_ovs #(.PARITY_MODE(1)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_baud_tick(tick), .i_rx(rx_b),
        .o_data(data_b), .o_valid(valid_b), .o_parity_err(perr_b),
        .o_frame_err(ferr_b), .o_idle(idle_b), .o_busy(busy_b)
    );

    always #5 clk = ~clk;

    // One baud tick every 4 clocks: 16 ticks = 64 clocks per bit.
    initial begin
        int div = 0;
        forever begin
            @(negedge clk);
            tick = (div == 3);
            if (div == 3) tick_total++;
            div = (div + 1) % 4;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (idle_a === 1'b1) begin
            idle_cnt_a++;
            last_idle_tick_a = tick_total;
        end
        if (valid_a === 1'b1) begin
            last_valid_tick_a = tick_total;
            n_cmp++;
            assert (q_a.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_valid_a: observed o_valid=1 data=%0h expected no frame", data_a);
            end
            if (q_a.size() > 0) begin
                e_a = q_a.pop_front();
                check("a_data", 32'(data_a), 32'(e_a.data));
                check("a_parity_err", 32'(perr_a), 32'(e_a.perr));
                check("a_frame_err", 32'(ferr_a), 32'(e_a.ferr));
            end
        end
        if (valid_b === 1'b1) begin
            n_cmp++;
            assert (q_b.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_valid_b: observed o_valid=1 data=%0h expected no frame", data_b);
            end
            if (q_b.size() > 0) begin
                e_b = q_b.pop_front();
                check("b_data", 32'(data_b), 32'(e_b.data));
                check("b_parity_err", 32'(perr_b), 32'(e_b.perr));
                check("b_frame_err", 32'(ferr_b), 32'(e_b.ferr));
            end
        end
    end

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic drive_bit(input bit sel, input logic v, input bit glitch);
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            set_rx(sel, (glitch && c >= 30 && c < 34) ? ~v : v);
        end
    endtask

    // abort_bit >= 0 leaves the task 20 clocks into that data bit, line still driven.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par, input logic pbit,
                              input logic stopv, input int glitch_bit, input int abort_bit);
        drive_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    set_rx(sel, d[i]);
                end
                return;
            end
            drive_bit(sel, d[i], (i == glitch_bit));
        end
        if (use_par) drive_bit(sel, pbit, 1'b0);
        drive_bit(sel, stopv, 1'b0);
    endtask

    task automatic push_a(input logic [7:0] d, input logic stopv);
        exp_t e;
        e.data = d;
        e.perr = 1'b0;
        e.ferr = ~stopv;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] d, input logic pbit);
        exp_t e;
        e.data = d;
        e.perr = (^d) ^ pbit;
        e.ferr = 1'b0;
        q_b.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((q_a.size() + q_b.size()) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(q_a.size() + q_b.size()), 32'd0);
    endtask

    initial begin
        int idle_before;
        int n;

        repeat (4) @(negedge clk);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_parity_err", 32'(perr_a), 32'd0);
        check("rst_frame_err", 32'(ferr_a), 32'd0);
        check("rst_idle", 32'(idle_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
        repeat (128) @(negedge clk);

        push_a(8'hA5, 1'b1);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, -1);
        wait_drain("drain_a5");

        // Line stays high after the frame: one timeout at 10 bit periods, then silence.
        idle_before = idle_cnt_a;
        n = 0;
        while (idle_cnt_a == idle_before && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("idle_seen", 32'(idle_cnt_a), 32'(idle_before + 1));
        check("idle_delay_ticks", 32'(last_idle_tick_a - last_valid_tick_a), 32'd160);
        repeat (2000) @(negedge clk);
        check("idle_single_pulse", 32'(idle_cnt_a), 32'(idle_before + 1));

        push_b(8'h3C, 1'b1);
        send_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, -1, -1);
        wait_drain("drain_3c_bad_par");
        push_b(8'h3C, 1'b0);
        send_frame(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, -1, -1);
        wait_drain("drain_3c_good_par");
        push_b(8'h07, 1'b1);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, -1, -1);
        wait_drain("drain_07_good_par");
        push_b(8'h07, 1'b0);
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, -1, -1);
        wait_drain("drain_07_bad_par");

        push_a(8'h55, 1'b0);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, -1, -1);
        wait_drain("drain_55_bad_stop");
        drive_bit(1'b0, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b0);
        push_a(8'h0F, 1'b1);
        send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, -1, -1);
        wait_drain("drain_0f_after_ferr");
        check("hold_data_0f", 32'(data_a), 32'h0F);
        check("hold_frame_err_0f", 32'(ferr_a), 32'd0);

        // Short low pulse: start detected, then rejected at mid-bit.
        repeat (64) @(negedge clk);
        rx_a = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_busy_high", 32'(busy_a), 32'd1);
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (80) @(negedge clk);
        check("glitch_busy_low", 32'(busy_a), 32'd0);
        check("glitch_data_held", 32'(data_a), 32'h0F);

`ifdef UART_RX_MAJORITY_EN
        push_a(8'h6B, 1'b1);
        send_frame(1'b0, 8'h6B, 1'b0, 1'b0, 1'b1, 3, -1);
        wait_drain("drain_6b_glitched_bit");
`endif

        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, -1, 4);
        check("midframe_busy", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_data", 32'(data_a), 32'd0);
        check("midrst_valid", 32'(valid_a), 32'd0);
        rx_a = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (256) @(negedge clk);
        check("postrst_busy", 32'(busy_a), 32'd0);

        push_a(8'h81, 1'b1);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, -1, -1);
        wait_drain("drain_81_after_rst");
        check("final_data_81", 32'(data_a), 32'h81);

        repeat (200) @(negedge clk);
        wait_drain("final_queues_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
